// File: rtl/pattern_count_engine_if.sv
// Engine <-> data memory bus: start/done handshake plus synchronous-read memory port.
// master is the engine side; slave is the memory/host side.
interface pattern_count_engine_if;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (
    input  start,
    input  mem_rd_data,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );

  modport slave (
    output start,
    output mem_rd_data,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );
endinterface

// File: rtl/pattern_count_engine.sv
// Streams a message and pattern byte out of data memory, counts 5-bit pattern
// occurrences (in-byte, per-byte, whole-string) and writes the three counts back.
module pattern_count_engine #(
  parameter int unsigned MSG_BYTES = 32,
  parameter int unsigned PAT_ADDR  = 32,
  parameter int unsigned RES_ADDR  = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pattern_count_engine_if.master bus
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned HW = 3;
  localparam int unsigned XW = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_WR0,
    S_WR1,
    S_WR2,
    S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            wr_en_q, wr_en_d;
  logic            done_q, done_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [3:0]      prev_q, prev_d;
  logic            first_q, first_d;
  logic [CW-1:0]   ctb_q, ctb_d;
  logic [CW-1:0]   cto_q, cto_d;
  logic [CW-1:0]   cts_q, cts_d;

  logic [DW-1:0]   cur_c;
  logic [XW-1:0]   win_c;
  logic [HW-1:0]   in_hits_c;
  logic [HW-1:0]   cross_hits_c;
  logic            consume_c;
  logic [DW-1:0]   wr_data_c;

  assign cur_c = bus.mem_rd_data;

  // Window matches for the byte on the read bus: low 4 windows are in-byte, high 4 straddle prev.
  always_comb begin
    win_c        = {prev_q, cur_c};
    in_hits_c    = '0;
    cross_hits_c = '0;
    for (int j = 0; j < 4; j++) begin
      if (win_c[j +: PW] == pat_q) in_hits_c = in_hits_c + HW'(1);
      if (win_c[j + 4 +: PW] == pat_q) cross_hits_c = cross_hits_c + HW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    wr_en_d    = 1'b0;
    done_d     = done_q;
    pat_d      = pat_q;
    prev_d     = prev_q;
    first_d    = first_q;
    ctb_d      = ctb_q;
    cto_d      = cto_q;
    cts_d      = cts_q;
    consume_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_FETCH;
          done_d     = 1'b0;
          ctb_d      = '0;
          cto_d      = '0;
          cts_d      = '0;
          pat_d      = '0;
          prev_d     = '0;
          first_d    = 1'b1;
          mem_addr_d = AW'(PAT_ADDR);
        end
      end
      S_FETCH: begin
        state_d    = S_STREAM;
        mem_addr_d = '0;
      end
      S_STREAM: begin
        // Pattern byte lands while address 0 is on the bus; message bytes follow one cycle behind.
        if (mem_addr_q == '0) begin
          pat_d = cur_c[DW-1:DW-PW];
        end else begin
          consume_c = 1'b1;
        end
        if (mem_addr_q == AW'(MSG_BYTES - 1)) begin
          state_d    = S_WR0;
          mem_addr_d = AW'(RES_ADDR);
          wr_en_d    = 1'b1;
        end else begin
          mem_addr_d = mem_addr_q + AW'(1);
        end
      end
      S_WR0: begin
        consume_c  = 1'b1;
        state_d    = S_WR1;
        mem_addr_d = AW'(RES_ADDR + 1);
        wr_en_d    = 1'b1;
      end
      S_WR1: begin
        state_d    = S_WR2;
        mem_addr_d = AW'(RES_ADDR + 2);
        wr_en_d    = 1'b1;
      end
      S_WR2: begin
        state_d    = S_FIN;
        mem_addr_d = '0;
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (consume_c) begin
      ctb_d   = ctb_q + CW'(in_hits_c);
      cto_d   = cto_q + CW'(in_hits_c != '0);
      cts_d   = cts_q + CW'(in_hits_c) + (first_q ? CW'(0) : CW'(cross_hits_c));
      prev_d  = cur_c[3:0];
      first_d = 1'b0;
    end
  end

  // ctb write must include the last byte, which only arrives during WR0 itself.
  always_comb begin
    wr_data_c = '0;
    case (state_q)
      S_WR0:   wr_data_c = ctb_d;
      S_WR1:   wr_data_c = cto_q;
      S_WR2:   wr_data_c = cts_q;
      default: wr_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      pat_q      <= '0;
      prev_q     <= '0;
      first_q    <= 1'b0;
      ctb_q      <= '0;
      cto_q      <= '0;
      cts_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      pat_q      <= pat_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      ctb_q      <= ctb_d;
      cto_q      <= cto_d;
      cts_q      <= cts_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_c;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Bench for pattern_count_engine: memory model, bit-string reference model,
// directed scenarios plus randomized messages.
module tb_pattern_count_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pattern_count_engine_if bus ();

  pattern_count_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] image [0:255];
  logic [7:0] msg   [0:31];
  logic [7:0] patb;

  int         wr0 = 0, wr1 = 0, wr2 = 0, bad_wr = 0;
  logic [7:0] res0 = '0, res1 = '0, res2 = '0;
  int         checks = 0, passes = 0, fails = 0;

  // Synchronous-read memory; write-backs are logged per result address.
  always @(posedge clk) bus.mem_rd_data <= image[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      case (bus.mem_addr)
        8'd33:   begin wr0 <= wr0 + 1; res0 <= bus.mem_wr_data; end
        8'd34:   begin wr1 <= wr1 + 1; res1 <= bus.mem_wr_data; end
        8'd35:   begin wr2 <= wr2 + 1; res2 <= bus.mem_wr_data; end
        default: bad_wr <= bad_wr + 1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: treat the message as a 256-bit string, byte 0 most significant.
  function automatic void model(output int ctb, output int cto, output int cts);
    logic [255:0] s;
    logic [4:0]   p;
    int           hits;
    p   = patb[7:3];
    ctb = 0;
    cto = 0;
    cts = 0;
    s   = '0;
    for (int k = 0; k < 32; k++) begin
      s[255 - 8 * k -: 8] = msg[k];
      hits = 0;
      for (int j = 0; j < 4; j++) if (msg[k][j +: 5] == p) hits++;
      ctb += hits;
      if (hits > 0) cto++;
    end
    for (int i = 0; i < 252; i++) if (s[i +: 5] == p) cts++;
  endfunction

  task automatic load();
    for (int k = 0; k < 32; k++) image[k] = msg[k];
    image[32] = patb;
  endtask

  task automatic set_all(input logic [7:0] v, input logic [7:0] p);
    for (int k = 0; k < 32; k++) msg[k] = v;
    patb = p;
  endtask

  // One full run from a negedge; optional extra start pulse while busy.
  task automatic run(input string tag, input int glitch_at);
    int ectb, ecto, ects, n, b0, b1, b2, bw;
    load();
    model(ectb, ecto, ects);
    b0 = wr0; b1 = wr1; b2 = wr2; bw = bad_wr;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk($sformatf("%s.done_clr", tag), 32'(bus.done), 32'd0);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start = (n == glitch_at);
      if (bus.done === 1'b1) break;
    end
    bus.start = 1'b0;
    chk($sformatf("%s.latency", tag), 32'(n), 32'd37);
    chk($sformatf("%s.wr_en_idle", tag), 32'(bus.mem_wr_en), 32'd0);
    chk($sformatf("%s.nwr33", tag), 32'(wr0 - b0), 32'd1);
    chk($sformatf("%s.nwr34", tag), 32'(wr1 - b1), 32'd1);
    chk($sformatf("%s.nwr35", tag), 32'(wr2 - b2), 32'd1);
    chk($sformatf("%s.ctb", tag), 32'(res0), 32'(ectb));
    chk($sformatf("%s.cto", tag), 32'(res1), 32'(ecto));
    chk($sformatf("%s.cts", tag), 32'(res2), 32'(ects));
    chk($sformatf("%s.stray_wr", tag), 32'(bad_wr - bw), 32'd0);
  endtask

  initial begin
    int tot;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    for (int a = 0; a < 256; a++) image[a] = 8'h00;
    set_all(8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst.addr", 32'(bus.mem_addr), 32'd0);
    chk("rst.wr_data", 32'(bus.mem_wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(8'h00, 8'h00); run("all00", 0);
    set_all(8'h55, 8'hA8); run("all55", 0);
    run("b2b", 0);
    set_all(8'hFF, 8'h00); run("allFF_p0", 0);
    set_all(8'hFF, 8'hF8); run("allFF_p1f", 0);
    set_all(8'h00, 8'hF8); msg[0] = 8'h03; msg[1] = 8'hE0; run("cross", 0);

    for (int k = 0; k < 32; k++) msg[k] = 8'($urandom);
    patb = 8'($urandom);
    run("busy_start", 10);

    // Reset in the middle of STREAM: no write-back, done stays low.
    set_all(8'h00, 8'h00);
    load();
    tot = wr0 + wr1 + wr2 + bad_wr;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("midrst.addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst.wr_data", 32'(bus.mem_wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (45) @(posedge clk);
    @(negedge clk);
    chk("midrst.no_wr", 32'(wr0 + wr1 + wr2 + bad_wr - tot), 32'd0);
    chk("midrst.done_low", 32'(bus.done), 32'd0);
    run("post_rst", 0);

    // Start coinciding with reset is dropped.
    tot = wr0 + wr1 + wr2 + bad_wr;
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    chk("rst_start.addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_start.done", 32'(bus.done), 32'd0);
    repeat (45) @(posedge clk);
    @(negedge clk);
    chk("rst_start.no_wr", 32'(wr0 + wr1 + wr2 + bad_wr - tot), 32'd0);
    chk("rst_start.done_low", 32'(bus.done), 32'd0);

    for (int r = 0; r < 8; r++) begin
      patb = 8'($urandom);
      for (int k = 0; k < 32; k++) begin
        if (r % 2 == 1) msg[k] = {patb[7:3], 3'($urandom)};
        else            msg[k] = 8'($urandom);
      end
      run($sformatf("rand%0d", r), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
